// File: rtl/usb_tx_arb_if.sv
// rtl/usb_tx_arb_if.sv - packet source and PHY TX stream bundle for usb_tx_arb
//
// Carries the per-channel source handshake (in_*) and the single PHY-side
// stream (out_*). The slave modport is the arbiter's view; the master modport
// is the view of whatever drives the sources and sinks the PHY stream.
interface usb_tx_arb_if #(
    parameter int NCH = 2,
    parameter int DW  = 8
);
    logic [NCH-1:0]    in_sop;
    logic [NCH-1:0]    in_eop;
    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_cancel;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]    in_ready;

    logic              out_sop;
    logic              out_eop;
    logic              out_cancel;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_ready;

    modport slave (
        input  in_sop, in_eop, in_valid, in_cancel, in_data,
        output in_ready,
        output out_sop, out_eop, out_cancel, out_valid, out_data,
        input  out_ready
    );

    modport master (
        output in_sop, in_eop, in_valid, in_cancel, in_data,
        input  in_ready,
        input  out_sop, out_eop, out_cancel, out_valid, out_data,
        output out_ready
    );
endinterface

// File: rtl/usb_tx_arb.sv
// rtl/usb_tx_arb.sv - N-source TX packet arbiter with output elastic FIFO
//
// Grants one source channel per packet (locked from SOP until EOP or cancel)
// and queues the accepted beats in a DEPTH-entry first-word-fall-through FIFO
// feeding the PHY TX stream.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   force_en/id     restrict new grants to channel force_id
//   bus (slave)     in_* per-channel sources / in_ready, out_* PHY stream / out_ready
//   pkt_start       PHY handshake of an SOP beat
//   orphan_err      a non-SOP beat was flushed while idle
//   busy            packet locked or FIFO non-empty
//   level           FIFO occupancy
module usb_tx_arb #(
    parameter int NCH    = 2,
    parameter int DW     = 8,
    parameter int DEPTH  = 4,
    parameter int ARB_RR = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       force_en,
    input  logic [$clog2(NCH)-1:0]     force_id,
    usb_tx_arb_if.slave                bus,
    output logic                       pkt_start,
    output logic                       orphan_err,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int IW = $clog2(NCH);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int BW = DW + 3;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [AW-1:0]   wr_q, wr_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [LW-1:0]   level_q, level_d;
    logic [BW-1:0]   mem_q [DEPTH];

    logic            full;
    logic            push;
    logic            pop;
    logic            orphan;
    logic [NCH-1:0]  elig;
    logic [NCH-1:0]  ready;
    logic            win_found;
    logic [IW-1:0]   win;
    logic [IW-1:0]   src;
    logic [BW-1:0]   push_word;
    logic [BW-1:0]   head;

    assign full = (level_q == LW'(DEPTH));
    assign pop  = (level_q != '0) & bus.out_ready;
    assign head = mem_q[rd_q];

    always_comb begin
        elig = '0;
        for (int i = 0; i < NCH; i++) begin
            elig[i] = bus.in_valid[i] & bus.in_sop[i] & (~force_en | (force_id == IW'(i)));
        end
    end

    // Winner search: plain lowest-index scan, or a scan starting at the
    // round-robin pointer and wrapping past NCH-1 back to 0.
    always_comb begin
        win_found = 1'b0;
        win       = '0;
        for (int k = 0; k < NCH; k++) begin
            if (ARB_RR != 0) begin
                if (!win_found && elig[(int'(rr_q) + k) % NCH]) begin
                    win_found = 1'b1;
                    win       = IW'((int'(rr_q) + k) % NCH);
                end
            end else begin
                if (!win_found && elig[k]) begin
                    win_found = 1'b1;
                    win       = IW'(k);
                end
            end
        end
    end

    // A cancel beat is stored with eop set so the PHY always sees a packet end.
    always_comb begin
        src       = (state_q == LOCKED) ? grant_q : win;
        push_word = {bus.in_cancel[src],
                     bus.in_eop[src] | bus.in_cancel[src],
                     bus.in_sop[src],
                     bus.in_data[int'(src)*DW +: DW]};
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        ready   = '0;
        push    = 1'b0;
        orphan  = 1'b0;
        case (state_q)
            IDLE: begin
                // Stray mid-packet beats are drained so they cannot wedge a source.
                for (int i = 0; i < NCH; i++) begin
                    if (bus.in_valid[i] && !bus.in_sop[i] && !full) begin
                        ready[i] = 1'b1;
                        orphan   = 1'b1;
                    end
                end
                if (win_found && !full) begin
                    ready[win] = 1'b1;
                    push       = 1'b1;
                    rr_d       = IW'((int'(win) + 1) % NCH);
                    if (!(bus.in_eop[win] || bus.in_cancel[win])) begin
                        state_d = LOCKED;
                        grant_d = win;
                    end
                end
            end
            LOCKED: begin
                ready[grant_q] = ~full;
                if (bus.in_valid[grant_q] && !full) begin
                    push = 1'b1;
                    if (bus.in_eop[grant_q] || bus.in_cancel[grant_q]) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_d    = push ? wr_q + 1'b1 : wr_q;
        rd_d    = pop  ? rd_q + 1'b1 : rd_q;
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!push && pop) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: every head field is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= push_word;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = (level_q != '0);
    assign bus.out_data   = bus.out_valid ? head[DW-1:0] : '0;
    assign bus.out_sop    = bus.out_valid & head[DW];
    assign bus.out_eop    = bus.out_valid & head[DW+1];
    assign bus.out_cancel = bus.out_valid & head[DW+2];

    assign pkt_start  = pop & head[DW];
    assign orphan_err = orphan;
    assign busy       = (state_q == LOCKED) | (level_q != '0);
    assign level      = level_q;
endmodule

// File: tb/tb_usb_tx_arb.sv
// tb/tb_usb_tx_arb.sv - self-checking bench for usb_tx_arb (fixed-priority and round-robin builds)
module tb_usb_tx_arb;
    localparam int DW = 8;

    typedef struct packed {
        logic          cancel;
        logic          eop;
        logic          sop;
        logic [DW-1:0] data;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       force_en;
    logic [1:0] force_id;
    logic       out_rdy;

    always #5 clk = ~clk;

    usb_tx_arb_if #(.NCH(2), .DW(DW)) bus_a ();
    usb_tx_arb_if #(.NCH(3), .DW(DW)) bus_b ();

    logic       pkt_start_a, orphan_a, busy_a;
    logic       pkt_start_b, orphan_b, busy_b;
    logic [2:0] level_a, level_b;

    usb_tx_arb #(.NCH(2), .DW(DW), .DEPTH(4), .ARB_RR(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .force_en(force_en), .force_id(force_id[0]),
        .bus(bus_a), .pkt_start(pkt_start_a), .orphan_err(orphan_a),
        .busy(busy_a), .level(level_a)
    );

    usb_tx_arb #(.NCH(3), .DW(DW), .DEPTH(4), .ARB_RR(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .force_en(force_en), .force_id(force_id),
        .bus(bus_b), .pkt_start(pkt_start_b), .orphan_err(orphan_b),
        .busy(busy_b), .level(level_b)
    );

    logic [2:0]  drv_valid [2];
    logic [2:0]  drv_sop [2];
    logic [2:0]  drv_eop [2];
    logic [2:0]  drv_cancel [2];
    logic [23:0] drv_data [2];

    assign bus_a.in_valid  = drv_valid[0][1:0];
    assign bus_a.in_sop    = drv_sop[0][1:0];
    assign bus_a.in_eop    = drv_eop[0][1:0];
    assign bus_a.in_cancel = drv_cancel[0][1:0];
    assign bus_a.in_data   = drv_data[0][15:0];
    assign bus_a.out_ready = out_rdy;
    assign bus_b.in_valid  = drv_valid[1];
    assign bus_b.in_sop    = drv_sop[1];
    assign bus_b.in_eop    = drv_eop[1];
    assign bus_b.in_cancel = drv_cancel[1];
    assign bus_b.in_data   = drv_data[1];
    assign bus_b.out_ready = out_rdy;

    logic [2:0] vld_s [2];
    logic [2:0] rdy_s [2];
    beat_t      head_s [2];
    logic       ov_s [2];
    logic       ps_s [2];
    logic       oe_s [2];
    logic       busy_s [2];
    logic [2:0] lv_s [2];

    assign vld_s[0]  = {1'b0, bus_a.in_valid};
    assign rdy_s[0]  = {1'b0, bus_a.in_ready};
    assign head_s[0] = {bus_a.out_cancel, bus_a.out_eop, bus_a.out_sop, bus_a.out_data};
    assign ov_s[0]   = bus_a.out_valid;
    assign ps_s[0]   = pkt_start_a;
    assign oe_s[0]   = orphan_a;
    assign busy_s[0] = busy_a;
    assign lv_s[0]   = level_a;
    assign vld_s[1]  = bus_b.in_valid;
    assign rdy_s[1]  = bus_b.in_ready;
    assign head_s[1] = {bus_b.out_cancel, bus_b.out_eop, bus_b.out_sop, bus_b.out_data};
    assign ov_s[1]   = bus_b.out_valid;
    assign ps_s[1]   = pkt_start_b;
    assign oe_s[1]   = orphan_b;
    assign busy_s[1] = busy_b;
    assign lv_s[1]   = level_b;

    // Source queues and load record are indexed dut*3 + channel.
    beat_t src_q [6][$];
    beat_t ld_q [6][$];
    beat_t out_q [2][$];
    beat_t exp_q [2][$];
    int    acc_ch [2][$];
    int    acc_t [2][$];
    int    exp_ch [2][$];
    int    ps_cnt [2];
    int    oe_cnt [2];
    int    max_lv [2];
    int    cyc;
    int    or_prob;
    int    checks = 0;
    int    errors = 0;

    task automatic drive();
        beat_t b;
        for (int d = 0; d < 2; d++) begin
            drv_valid[d] = '0; drv_sop[d] = '0; drv_eop[d] = '0; drv_cancel[d] = '0; drv_data[d] = '0;
            for (int ch = 0; ch < 3; ch++) begin
                if (src_q[d*3+ch].size() > 0) begin
                    b = src_q[d*3+ch][0];
                    drv_valid[d][ch]         = 1'b1;
                    drv_sop[d][ch]           = b.sop;
                    drv_eop[d][ch]           = b.eop;
                    drv_cancel[d][ch]        = b.cancel;
                    drv_data[d][ch*8 +: 8]   = b.data;
                end
            end
        end
        out_rdy = ($urandom_range(99) < or_prob);
    endtask

    task automatic run_cycles(input int n);
        bit hs [6];
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int ch = 0; ch < 3; ch++) begin
                    hs[d*3+ch] = vld_s[d][ch] && rdy_s[d][ch];
                    if (hs[d*3+ch]) begin
                        acc_ch[d].push_back(ch);
                        acc_t[d].push_back(cyc);
                    end
                end
                if (ov_s[d] && out_rdy) out_q[d].push_back(head_s[d]);
                if (ps_s[d]) ps_cnt[d]++;
                if (oe_s[d]) oe_cnt[d]++;
                if (int'(lv_s[d]) > max_lv[d]) max_lv[d] = int'(lv_s[d]);
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 6; i++) begin
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            end
            cyc++;
            drive();
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        force_en = 1'b0;
        force_id = 2'd0;
        or_prob  = 100;
        for (int i = 0; i < 6; i++) begin
            src_q[i].delete();
            ld_q[i].delete();
        end
        for (int d = 0; d < 2; d++) begin
            out_q[d].delete(); exp_q[d].delete(); acc_ch[d].delete(); acc_t[d].delete(); exp_ch[d].delete();
            ps_cnt[d] = 0; oe_cnt[d] = 0; max_lv[d] = 0;
        end
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    // Packet of len beats with random data; the last beat ends with eop or cancel.
    task automatic load_both(input int ch, input int len, input bit canc);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data   = DW'($urandom);
            b.sop    = (i == 0);
            b.eop    = (i == len - 1) && !canc;
            b.cancel = (i == len - 1) && canc;
            for (int d = 0; d < 2; d++) begin
                if (d == 1 || ch < 2) begin
                    src_q[d*3+ch].push_back(b);
                    ld_q[d*3+ch].push_back(b);
                end
            end
        end
    endtask

    function automatic void exp_append(input int d, input int ch);
        beat_t b;
        for (int i = 0; i < ld_q[d*3+ch].size(); i++) begin
            b     = ld_q[d*3+ch][i];
            b.eop = b.eop | b.cancel;
            exp_q[d].push_back(b);
            exp_ch[d].push_back(ch);
        end
    endfunction

    // Packet-level reference: at each packet boundary pick a channel with a
    // pending packet (lowest index, or first from the rotating pointer) and
    // send that whole packet.
    function automatic void model(input int d, input int nch, input bit rr);
        beat_t q [3][$];
        beat_t b;
        int    ptr = 0;
        int    win;
        bit    last;
        exp_q[d].delete();
        exp_ch[d].delete();
        for (int ch = 0; ch < nch; ch++) q[ch] = ld_q[d*3+ch];
        forever begin
            win = -1;
            for (int k = 0; k < nch; k++) begin
                int c;
                c = rr ? (ptr + k) % nch : k;
                if (win < 0 && q[c].size() > 0) win = c;
            end
            if (win < 0) break;
            last = 1'b0;
            while (!last && q[win].size() > 0) begin
                b     = q[win].pop_front();
                last  = b.eop | b.cancel;
                b.eop = last;
                exp_q[d].push_back(b);
                exp_ch[d].push_back(win);
            end
            ptr = (win + 1) % nch;
        end
    endfunction

    function automatic int diff_out(input int d);
        for (int i = 0; i < out_q[d].size() && i < exp_q[d].size(); i++)
            if (out_q[d][i] !== exp_q[d][i]) return i;
        if (out_q[d].size() != exp_q[d].size()) return (out_q[d].size() < exp_q[d].size()) ? out_q[d].size() : exp_q[d].size();
        return -1;
    endfunction

    function automatic int diff_acc(input int d);
        for (int i = 0; i < acc_ch[d].size() && i < exp_ch[d].size(); i++)
            if (acc_ch[d][i] != exp_ch[d][i]) return i;
        if (acc_ch[d].size() != exp_ch[d].size()) return (acc_ch[d].size() < exp_ch[d].size()) ? acc_ch[d].size() : exp_ch[d].size();
        return -1;
    endfunction

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while (n < max && (src_q[0].size() + src_q[1].size() + src_q[3].size() + src_q[4].size() + src_q[5].size() > 0
                           || busy_s[0] || busy_s[1])) begin
            run_cycles(1);
            n++;
        end
        checks++;
        if (n >= max) begin
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
            errors++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({ov_s[d], lv_s[d], busy_s[d], ps_s[d], oe_s[d], rdy_s[d]} !== '0 || head_s[d] !== '0) begin
                $display("FAIL reset_state dut%0d: valid=%0b level=%0d busy=%0b ps=%0b oe=%0b rdy=%b head=%h, required all 0",
                         d, ov_s[d], lv_s[d], busy_s[d], ps_s[d], oe_s[d], rdy_s[d], head_s[d]);
                errors++;
            end
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        load_both(0, 3, 1'b0);
        load_both(1, 3, 1'b0);
        drive();
        model(0, 2, 1'b0);
        model(1, 3, 1'b1);
        wait_idle("fixed", 200);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (diff_out(d) != -1) begin
                $display("FAIL fixed_out dut%0d: mismatch at beat %0d, got %0d beats, required %0d", d, diff_out(d), out_q[d].size(), exp_q[d].size());
                errors++;
            end
            checks++;
            if (diff_acc(d) != -1) begin
                $display("FAIL fixed_accept_order dut%0d: mismatch at beat %0d", d, diff_acc(d));
                errors++;
            end
            checks++;
            if (ps_cnt[d] != 2) begin
                $display("FAIL fixed_pkt_start dut%0d: got %0d, required 2", d, ps_cnt[d]);
                errors++;
            end
        end
    endtask

    task automatic test_round_robin();
        int rr_exp [6] = '{0, 1, 2, 0, 1, 2};
        do_reset();
        for (int rep = 0; rep < 2; rep++)
            for (int ch = 0; ch < 3; ch++) load_both(ch, 1, 1'b0);
        drive();
        model(0, 2, 1'b0);
        model(1, 3, 1'b1);
        wait_idle("rr", 200);
        checks++;
        if (acc_ch[1].size() != 6) begin
            $display("FAIL rr_count: got %0d grants, required 6", acc_ch[1].size());
            errors++;
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (acc_ch[1][i] != rr_exp[i]) begin
                    $display("FAIL rr_order[%0d]: got ch%0d, required ch%0d", i, acc_ch[1][i], rr_exp[i]);
                    errors++;
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (diff_out(d) != -1 || diff_acc(d) != -1) begin
                $display("FAIL rr_stream dut%0d: out mismatch at %0d, accept mismatch at %0d, required none", d, diff_out(d), diff_acc(d));
                errors++;
            end
        end
    endtask

    task automatic test_backpressure();
        beat_t h0 [2];
        do_reset();
        or_prob = 0;
        load_both(0, 6, 1'b0);
        drive();
        run_cycles(10);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (lv_s[d] !== 3'd4 || rdy_s[d][0] !== 1'b0 || !busy_s[d]) begin
                $display("FAIL bp_full dut%0d: level=%0d rdy0=%0b busy=%0b, required level=4 rdy0=0 busy=1", d, lv_s[d], rdy_s[d][0], busy_s[d]);
                errors++;
            end
            h0[d] = head_s[d];
            checks++;
            if (h0[d] !== ld_q[d*3][0] || !ov_s[d]) begin
                $display("FAIL bp_head dut%0d: head=%h valid=%0b, required %h valid=1", d, h0[d], ov_s[d], ld_q[d*3][0]);
                errors++;
            end
        end
        run_cycles(3);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (head_s[d] !== h0[d]) begin
                $display("FAIL bp_hold dut%0d: head=%h, required %h", d, head_s[d], h0[d]);
                errors++;
            end
        end
        or_prob = 100;
        drive();
        model(0, 2, 1'b0);
        model(1, 3, 1'b1);
        wait_idle("bp", 200);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (diff_out(d) != -1 || lv_s[d] !== 3'd0 || max_lv[d] != 4) begin
                $display("FAIL bp_drain dut%0d: mismatch at %0d, level=%0d, max level=%0d, required none/0/4", d, diff_out(d), lv_s[d], max_lv[d]);
                errors++;
            end
        end
    endtask

    task automatic test_cancel();
        do_reset();
        load_both(1, 2, 1'b1);
        drive();
        run_cycles(1);
        load_both(0, 2, 1'b0);
        drive();
        wait_idle("cancel", 200);
        for (int d = 0; d < 2; d++) begin
            exp_q[d].delete();
            exp_ch[d].delete();
            exp_append(d, 1);
            exp_append(d, 0);
            checks++;
            if (diff_out(d) != -1 || diff_acc(d) != -1) begin
                $display("FAIL cancel_stream dut%0d: out mismatch at %0d, accept mismatch at %0d, required none", d, diff_out(d), diff_acc(d));
                errors++;
            end
            checks++;
            if (out_q[d].size() < 2 || out_q[d][1].cancel !== 1'b1 || out_q[d][1].eop !== 1'b1) begin
                $display("FAIL cancel_flags dut%0d: second beat cancel/eop missing, required cancel=1 eop=1", d);
                errors++;
            end
            checks++;
            if (acc_t[d].size() < 3 || acc_t[d][2] != acc_t[d][1] + 1) begin
                $display("FAIL cancel_regrant dut%0d: ch0 SOP not accepted the cycle after cancel, required gap 1", d);
                errors++;
            end
        end
    endtask

    task automatic test_orphan_force();
        beat_t b;
        do_reset();
        b = '{cancel: 1'b0, eop: 1'b0, sop: 1'b0, data: 8'h5A};
        src_q[0].push_back(b);
        src_q[3].push_back(b);
        drive();
        run_cycles(4);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (oe_cnt[d] != 1 || out_q[d].size() != 0 || src_q[d*3].size() != 0 || lv_s[d] !== 3'd0) begin
                $display("FAIL orphan dut%0d: pulses=%0d out=%0d pending=%0d level=%0d, required 1/0/0/0",
                         d, oe_cnt[d], out_q[d].size(), src_q[d*3].size(), lv_s[d]);
                errors++;
            end
        end
        do_reset();
        force_en = 1'b1;
        force_id = 2'd1;
        load_both(0, 2, 1'b0);
        load_both(1, 3, 1'b0);
        drive();
        run_cycles(12);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (src_q[d*3].size() != 2 || out_q[d].size() != 3) begin
                $display("FAIL force_only_ch1 dut%0d: ch0 pending=%0d out=%0d, required 2/3", d, src_q[d*3].size(), out_q[d].size());
                errors++;
            end
        end
        force_en = 1'b0;
        drive();
        wait_idle("force", 200);
        for (int d = 0; d < 2; d++) begin
            exp_q[d].delete();
            exp_ch[d].delete();
            exp_append(d, 1);
            exp_append(d, 0);
            checks++;
            if (diff_out(d) != -1 || diff_acc(d) != -1) begin
                $display("FAIL force_stream dut%0d: out mismatch at %0d, accept mismatch at %0d, required none", d, diff_out(d), diff_acc(d));
                errors++;
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        or_prob = 0;
        load_both(0, 8, 1'b0);
        drive();
        run_cycles(3);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (lv_s[d] !== 3'd3 || !busy_s[d]) begin
                $display("FAIL rstmid_setup dut%0d: level=%0d busy=%0b, required 3/1", d, lv_s[d], busy_s[d]);
                errors++;
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ov_s[d] !== 1'b0 || lv_s[d] !== 3'd0 || busy_s[d] !== 1'b0) begin
                $display("FAIL rstmid_async dut%0d: valid=%0b level=%0d busy=%0b, required 0/0/0", d, ov_s[d], lv_s[d], busy_s[d]);
                errors++;
            end
        end
        do_reset();
        load_both(1, 2, 1'b0);
        drive();
        model(0, 2, 1'b0);
        model(1, 3, 1'b1);
        wait_idle("rstmid", 200);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (diff_out(d) != -1 || diff_acc(d) != -1) begin
                $display("FAIL rstmid_fresh dut%0d: out mismatch at %0d, accept mismatch at %0d, required none", d, diff_out(d), diff_acc(d));
                errors++;
            end
        end
    endtask

    task automatic test_random();
        int nsop;
        for (int round = 0; round < 4; round++) begin
            do_reset();
            or_prob = 50 + $urandom_range(50);
            for (int ch = 0; ch < 3; ch++) begin
                int np;
                np = $urandom_range(3);
                for (int p = 0; p < np; p++) load_both(ch, 1 + $urandom_range(3), ($urandom_range(4) == 0));
            end
            drive();
            model(0, 2, 1'b0);
            model(1, 3, 1'b1);
            wait_idle("random", 2000);
            for (int d = 0; d < 2; d++) begin
                nsop = 0;
                for (int i = 0; i < exp_q[d].size(); i++) if (exp_q[d][i].sop) nsop++;
                checks++;
                if (diff_out(d) != -1 || diff_acc(d) != -1) begin
                    $display("FAIL random_stream r%0d dut%0d: out mismatch at %0d, accept mismatch at %0d, required none", round, d, diff_out(d), diff_acc(d));
                    errors++;
                end
                checks++;
                if (ps_cnt[d] != nsop || oe_cnt[d] != 0 || max_lv[d] > 4) begin
                    $display("FAIL random_status r%0d dut%0d: pkt_start=%0d orphan=%0d max level=%0d, required %0d/0/<=4",
                             round, d, ps_cnt[d], oe_cnt[d], max_lv[d], nsop);
                    errors++;
                end
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        force_en = 1'b0;
        force_id = 2'd0;
        out_rdy  = 1'b0;
        or_prob  = 100;
        cyc      = 0;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_backpressure();
        test_cancel();
        test_orphan_force();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
